ss_mult_sched: RTL
==================

// Module: ss_mult_sched
// PURPOSE
//  Arbitrates and sequences the shared iterative multiplier units for the superscalar issue stage.
//  Each cycle it takes per-slot multiply requests from issue and grants free units round-robin.
//  It tracks each unit's IDLE/BUSY/DONE occupancy and stalls slots it cannot serve.
//  It presents completed tags toward the CDB with a valid/ready handshake and flushes all work on ROB rollback.
// PARAMETERS
//  WIDTH     2  issue slots (requesters)
//  N_MULT    2  multiplier units; each is non-pipelined and busy for LATENCY cycles
//  LATENCY   4  cycles from grant to result (>=2)
//  TAG_W     6  destination physical-register tag width
// PORTS
//  clock          in   1               system clock, rising edge
//  reset          in   1               asynchronous, active-low reset
//  rollback_en    in   1               ROB rollback; flush everything
//  req_valid      in   WIDTH           slot i holds a valid MUL/MULH/MULHSU/MULHU op
//  req_tag        in   WIDTH*TAG_W     dest tag per slot, slot i at [i*TAG_W +: TAG_W]
//  grant          out  WIDTH           slot i accepted this cycle (drives RS delete_confirm)
//  stall_mul      out  WIDTH           req_valid & ~grant
//  unit_start     out  N_MULT          unit u begins an op this cycle
//  unit_src_slot  out  N_MULT*$clog2(WIDTH)  issue slot feeding unit u when unit_start[u]
//  done_valid     out  N_MULT          unit u holds a finished result
//  done_tag       out  N_MULT*TAG_W    tag of the finished result per unit
//  done_ready     in   N_MULT          CDB accepts unit u's result this cycle
// BEHAVIOUR
//  - Per-unit state: IDLE/BUSY/DONE, plus down-counter (clog2(LATENCY) bits) and latched tag.
//  - Also stored: rr_ptr ($clog2(WIDTH) bits), the slot with highest priority.
//  - Reset (reset==0, async):
//      all units IDLE; counters 0; tags 0; rr_ptr 0.
//      grant, stall_mul, unit_start, unit_src_slot, done_valid and done_tag are all 0.
//      grant stays 0 while reset is low, regardless of req_valid.
//  - grant, stall_mul, unit_start and unit_src_slot are combinational from the current state and inputs.
//  - Grant rule: scan slots rr_ptr, rr_ptr+1, ... mod WIDTH.
//      Each requesting slot takes the lowest-index IDLE unit not yet claimed this cycle.
//      Stop when IDLE units run out.
//  - A unit in BUSY or DONE is never granted. A DONE unit freed by done_ready becomes IDLE next cycle.
//      It is not re-granted in the same cycle it is freed.
//  - Grant in cycle t: unit goes BUSY at the edge ending t; done_valid[u] first high in cycle t+LATENCY.
//      done_tag[u] = req_tag of the granted slot, latched at grant.
//  - DONE: done_valid stays high and done_tag stays stable until done_ready[u] is sampled high.
//      The unit is IDLE the following cycle. done_ready while not DONE is ignored.
//  - rr_ptr: if any grant, it moves to (last granted slot + 1) mod WIDTH at the edge. Otherwise it holds.
//  - Rollback (rollback_en==1 in cycle t):
//      grant, unit_start and done_valid are forced 0 in cycle t.
//      stall_mul = req_valid in cycle t.
//      At the edge, every unit goes IDLE and counters clear; rr_ptr holds.
//      No result from a flushed op ever appears.
//  - rollback_en together with done_ready: rollback wins; the result is discarded.
//  - Reset asserted mid-operation: immediate return to reset values; no partial completion afterwards.
//  - Multiple units may reach DONE in the same cycle; each handshakes independently.
// CONFIGURATION
//  MULT_SCHED_PERF_EN
//    defined: adds output stall_cycles (out, 32), reset to 0.
//      Increments by 1 on each non-rollback cycle with |stall_mul; saturates at 32'hFFFF_FFFF.
//    undefined: the port and counter are absent; all other behaviour is identical.
// TESTING
//  1. reset=0, req_valid=2'b11 for 3 cycles -> grant=0, done_valid=0.
//     Release reset, then req_valid=2'b11 -> grant=2'b11 in the first cycle.
//  2. Defaults; cycle 0: req_valid=11, tags 5 and 9, done_ready=11.
//     Expect unit_start=11 and unit_src_slot={1,0} in cycle 0.
//     Expect done_valid=11 with done_tag={9,5} in cycle 4 only.
//  3. Both units BUSY; req_valid=01 -> grant=00, stall_mul=01.
//     Once done_ready frees unit 0 -> unit 0 is granted the following cycle.
//  4. Unit 0 DONE with tag 7, done_ready[0]=0 for 5 cycles -> done_valid[0]=1, tag 7 held, no grant to unit 0.
//     done_ready[0]=1 -> IDLE next cycle.
//  5. Grant in cycle 0; rollback_en=1 in cycle 2 -> both units IDLE from cycle 3.
//     done_valid stays 0 through cycle 10.
//  6. N_MULT=1, LATENCY=2, req_valid=11 held, done_ready=1 -> grants alternate slot0, slot1, slot0.
//     With MULT_SCHED_PERF_EN defined, stall_cycles counts every held cycle.

Source files
------------

// File: rtl/ss_mult_sched.sv
// ss_mult_sched: round-robin scheduler for the shared iterative multiplier units
// of the superscalar issue stage. Grants free units to requesting issue slots,
// tracks per-unit IDLE/BUSY/DONE occupancy, presents finished tags with a
// valid/ready handshake, and flushes all in-flight work on ROB rollback.
// Optional build macro: MULT_SCHED_PERF_EN adds the 32-bit stall_cycles counter.

// One multiplier occupancy tracker: IDLE -> BUSY (LATENCY-1 cycles) -> DONE.
module ss_mult_unit #(
  parameter int TAG_W   = 6,
  parameter int LATENCY = 4,
  parameter int CW      = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rollback_en,
  input  logic             start,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             done_ready,
  output logic             idle,
  output logic             done,
  output logic [TAG_W-1:0] tag
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} st_t;

  st_t           st;
  logic [CW-1:0] cnt;

  // Occupancy FSM; cnt is loaded so DONE is first visible LATENCY cycles after the grant.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st  <= IDLE;
      cnt <= '0;
      tag <= '0;
    end else if (rollback_en) begin
      st  <= IDLE;
      cnt <= '0;
    end else begin
      case (st)
        IDLE: if (start) begin
          st  <= BUSY;
          cnt <= CW'(LATENCY - 2);
          tag <= tag_in;
        end
        BUSY: if (cnt == '0) st <= DONE;
              else           cnt <= cnt - 1'b1;
        DONE: if (done_ready) st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

  assign idle = (st == IDLE);
  assign done = (st == DONE);
endmodule

module ss_mult_sched #(
  parameter int WIDTH   = 2,
  parameter int N_MULT  = 2,
  parameter int LATENCY = 4,
  parameter int TAG_W   = 6
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              rollback_en,
  input  logic [WIDTH-1:0]                  req_valid,
  input  logic [WIDTH*TAG_W-1:0]            req_tag,
  output logic [WIDTH-1:0]                  grant,
  output logic [WIDTH-1:0]                  stall_mul,
  output logic [N_MULT-1:0]                 unit_start,
  output logic [N_MULT*$clog2(WIDTH)-1:0]   unit_src_slot,
  output logic [N_MULT-1:0]                 done_valid,
  output logic [N_MULT*TAG_W-1:0]           done_tag,
  input  logic [N_MULT-1:0]                 done_ready
`ifdef MULT_SCHED_PERF_EN
  ,output logic [31:0]                      stall_cycles
`endif
);
  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(LATENCY);

  logic [SW-1:0]          rr_ptr;
  logic [N_MULT-1:0]      idle, done;
  logic [WIDTH-1:0]       grant_c;
  logic [N_MULT-1:0]      start_c, claimed;
  logic [N_MULT*SW-1:0]   src_c;
  logic [SW-1:0]          last, slot;
  logic                   any, found;
  logic                   en;

  // No grants while held in reset or during a rollback cycle.
  assign en = reset & ~rollback_en;

  // Round-robin scan from rr_ptr; each requester takes the lowest free unclaimed unit.
  always_comb begin
    grant_c = '0;
    start_c = '0;
    claimed = '0;
    src_c   = '0;
    last    = '0;
    slot    = '0;
    any     = 1'b0;
    found   = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      slot  = SW'((int'(rr_ptr) + k) % WIDTH);
      found = 1'b0;
      if (req_valid[slot]) begin
        for (int u = 0; u < N_MULT; u++) begin
          if (!found && idle[u] && !claimed[u]) begin
            found             = 1'b1;
            claimed[u]        = 1'b1;
            start_c[u]        = 1'b1;
            src_c[u*SW +: SW] = slot;
            grant_c[slot]     = 1'b1;
            last              = slot;
            any               = 1'b1;
          end
        end
      end
    end
  end

  assign grant         = en ? grant_c : '0;
  assign unit_start    = en ? start_c : '0;
  assign unit_src_slot = en ? src_c   : '0;
  assign stall_mul     = reset ? (req_valid & ~grant) : '0;
  assign done_valid    = rollback_en ? '0 : done;

  // Priority moves past the last slot served; holds when nothing is granted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)          rr_ptr <= '0;
    else if (en && any)  rr_ptr <= SW'((int'(last) + 1) % WIDTH);
  end

  for (genvar u = 0; u < N_MULT; u++) begin : g_unit
    ss_mult_unit #(.TAG_W(TAG_W), .LATENCY(LATENCY), .CW(CW)) u_unit (
      .clock       (clock),
      .reset       (reset),
      .rollback_en (rollback_en),
      .start       (unit_start[u]),
      .tag_in      (req_tag[int'(src_c[u*SW +: SW])*TAG_W +: TAG_W]),
      .done_ready  (done_ready[u]),
      .idle        (idle[u]),
      .done        (done[u]),
      .tag         (done_tag[u*TAG_W +: TAG_W])
    );
  end

`ifdef MULT_SCHED_PERF_EN
  // Saturating count of non-rollback cycles in which some slot stalled.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      stall_cycles <= '0;
    else if (!rollback_en && (|stall_mul) && (stall_cycles != 32'hFFFF_FFFF))
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif
endmodule
